serial_frame_deser: RTL and testbench

- Sits directly downstream of the enabled single-bit register stage.
- Consumes that stage's serial bit output together with a per-bit enable strobe.
- Hunts for a fixed sync pattern in the bit stream, then captures the following WIDTH payload bits MSB-first.
- Presents each payload as a parallel word with a one-cycle valid pulse and keeps a running frame count.

---
 rtl/serial_frame_deser_if.sv | 22 ++
 rtl/serial_frame_deser.sv | 83 ++++++++
 tb/tb_serial_frame_deser.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_deser_if.sv
// Bit-stream input and parallel-word output bundle of the serial frame deserializer.
interface serial_frame_deser_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             bit_in;
    logic             bit_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output bit_in, bit_en,
        input  word_out, word_valid, busy, frame_count
    );

    modport slave (
        input  bit_in, bit_en,
        output word_out, word_valid, busy, frame_count
    );
endinterface

// File: rtl/serial_frame_deser.sv
// Hunts a sync pattern in an enabled bit stream, then captures WIDTH payload bits MSB-first.
//   state   | meaning
//   HUNT    | sliding sync window over accepted bits, waiting for SYNC_PAT
//   CAPTURE | shifting in payload bits; word emitted on the WIDTH-th bit
module serial_frame_deser #(
    parameter int                  WIDTH    = 8,
    parameter int                  SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1011,
    parameter int                  CNT_W    = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_frame_deser_if.slave bus
);
    localparam int FILL_W = $clog2(SYNC_LEN + 1);
    localparam int BCNT_W = $clog2(WIDTH);

    typedef enum logic {HUNT, CAPTURE} state_t;

    state_t              state_q;
    logic [SYNC_LEN-2:0] window_q;
    logic [FILL_W-1:0]   fill_q;
    logic [WIDTH-2:0]    shift_q;
    logic [BCNT_W-1:0]   bit_cnt_q;

    logic [SYNC_LEN-1:0] window_next;
    logic [FILL_W-1:0]   fill_next;
    logic [WIDTH-1:0]    shift_next;
    logic                sync_hit;
    logic                last_bit;

    // Only the low SYNC_LEN-1 / WIDTH-1 bits are stored; the new bit completes the full value.
    always_comb begin
        window_next = {window_q, bus.bit_in};
        fill_next   = (fill_q == FILL_W'(SYNC_LEN)) ? fill_q : fill_q + 1'b1;
        shift_next  = {shift_q, bus.bit_in};
        sync_hit    = (window_next == SYNC_PAT) && (fill_next == FILL_W'(SYNC_LEN));
        last_bit    = (bit_cnt_q == BCNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= HUNT;
            window_q        <= '0;
            fill_q          <= '0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            bus.word_out    <= '0;
            bus.word_valid  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            bus.word_valid <= 1'b0;
            if (bus.bit_en) begin
                case (state_q)
                    HUNT: begin
                        window_q <= window_next[SYNC_LEN-2:0];
                        fill_q   <= fill_next;
                        if (sync_hit) begin
                            state_q   <= CAPTURE;
                            bit_cnt_q <= '0;
                            bus.busy  <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        shift_q   <= shift_next[WIDTH-2:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            bus.word_out    <= shift_next;
                            bus.word_valid  <= 1'b1;
                            bus.frame_count <= bus.frame_count + 1'b1;
                            state_q         <= HUNT;
                            window_q        <= '0;
                            fill_q          <= '0;
                            bus.busy        <= 1'b0;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_deser.sv
// Randomized bench for serial_frame_deser against a queue-based frame model.
module tb_serial_frame_deser;
    localparam int WIDTH    = 8;
    localparam int SYNC_LEN = 4;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst_n;
    logic [SYNC_LEN-1:0] sync_pat;

    serial_frame_deser_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_frame_deser #(
        .WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .SYNC_PAT(4'b1011), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // reference model: recent hunting bits and collected payload bits
    bit             hist[$];
    bit             pay[$];
    bit             m_cap;
    logic [WIDTH-1:0] m_word;
    logic [CNT_W-1:0] m_count;
    bit             exp_valid;

    // per-scenario observations
    int   obs_pulses;
    int   dbl;
    int   cyc_bad;
    bit   prev_valid;

    task automatic model_reset();
        hist.delete();
        pay.delete();
        m_cap      = 0;
        m_word     = '0;
        m_count    = '0;
        obs_pulses = 0;
        dbl        = 0;
        cyc_bad    = 0;
        prev_valid = 0;
    endtask

    function automatic bit hist_is_sync();
        if (hist.size() != SYNC_LEN) return 0;
        for (int i = 0; i < SYNC_LEN; i++)
            if (hist[i] != sync_pat[SYNC_LEN-1-i]) return 0;
        return 1;
    endfunction

    // Drive one cycle from a negedge, advance the model, observe just after the posedge.
    task automatic step(input bit b, input bit en);
        logic [WIDTH-1:0] w;
        bus.bit_in = b;
        bus.bit_en = en;
        exp_valid  = 0;
        if (en) begin
            if (!m_cap) begin
                hist.push_back(b);
                if (hist.size() > SYNC_LEN) void'(hist.pop_front());
                if (hist_is_sync()) begin
                    m_cap = 1;
                    pay.delete();
                end
            end else begin
                pay.push_back(b);
                if (pay.size() == WIDTH) begin
                    w = '0;
                    foreach (pay[i]) w = {w[WIDTH-2:0], pay[i]};
                    m_word    = w;
                    m_count   = m_count + 1'b1;
                    exp_valid = 1;
                    m_cap     = 0;
                    hist.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        if (bus.word_valid === 1'b1) obs_pulses++;
        if (bus.word_valid === 1'b1 && prev_valid) dbl++;
        prev_valid = (bus.word_valid === 1'b1);
        if (bus.word_valid !== exp_valid || bus.busy !== m_cap ||
            bus.word_out !== m_word || bus.frame_count !== m_count)
            cyc_bad++;
        @(negedge clk);
    endtask

    task automatic send_sync(input bit gaps);
        for (int i = SYNC_LEN - 1; i >= 0; i--) begin
            step(sync_pat[i], 1'b1);
            if (gaps) step(1'($urandom), 1'b0);
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(w[i], 1'b1);
            if (gaps) step(1'($urandom), 1'b0);
        end
    endtask

    // Async reset asserted between edges; caller inspects outputs, then calls release_reset.
    task automatic assert_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (bus.word_out !== '0 || bus.word_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.frame_count !== '0) begin
            failures++;
            $display("FAIL %s_zero: word_out=%h valid=%b busy=%b count=%h, required all zero",
                     tag, bus.word_out, bus.word_valid, bus.busy, bus.frame_count);
        end
    endtask

    task automatic test_reset();
        send_sync(0);
        send_word(8'h5A, 0);
        checks++;
        if (bus.frame_count !== 8'd1 || bus.word_out !== 8'h5A) begin
            failures++;
            $display("FAIL reset_pre_frame: word=%h count=%h, required 5a/01", bus.word_out, bus.frame_count);
        end
        assert_reset();
        check_zero_outputs("reset_async");
        release_reset();
    endtask

    task automatic check_frame(input string tag, input logic [WIDTH-1:0] w, input int pulses);
        checks++;
        if (bus.word_out !== w) begin
            failures++;
            $display("FAIL %s_word: got %h required %h", tag, bus.word_out, w);
        end
        checks++;
        if (bus.frame_count !== m_count) begin
            failures++;
            $display("FAIL %s_count: got %0d required %0d", tag, bus.frame_count, m_count);
        end
        checks++;
        if (obs_pulses !== pulses || dbl !== 0) begin
            failures++;
            $display("FAIL %s_pulses: got %0d (double %0d) required %0d", tag, obs_pulses, dbl, pulses);
        end
        checks++;
        if (cyc_bad !== 0) begin
            failures++;
            $display("FAIL %s_cycle: %0d cycles differed from model, required 0", tag, cyc_bad);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_end: got %b required 0", tag, bus.busy);
        end
    endtask

    task automatic test_basic();
        send_sync(0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b required 1", bus.busy);
        end
        send_word(8'hA5, 0);
        check_frame("basic", 8'hA5, 1);
        checks++;
        if (bus.frame_count !== 8'd1) begin
            failures++;
            $display("FAIL basic_count1: got %0d required 1", bus.frame_count);
        end
    endtask

    task automatic test_gaps();
        assert_reset();
        release_reset();
        send_sync(1);
        send_word(8'hA5, 1);
        repeat (3) step(1'($urandom), 1'b0);
        check_frame("gaps", 8'hA5, 1);
    endtask

    task automatic test_junk();
        logic [6:0] junk;
        assert_reset();
        release_reset();
        junk = 7'b1101011;
        for (int i = 6; i >= 0; i--) begin
            step(junk[i], 1'b1);
            if (i == 1) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL junk_early_sync: busy=%b after 6th bit, required 0", bus.busy);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL junk_sync7: busy=%b after 7th bit, required 1", bus.busy);
        end
        send_word(8'h3C, 0);
        check_frame("junk", 8'h3C, 1);
    endtask

    task automatic test_sync_in_payload();
        logic [3:0] tail;
        assert_reset();
        release_reset();
        tail = 4'b0011;
        send_sync(0);
        send_word(8'h0B, 0);
        for (int i = 3; i >= 0; i--) step(tail[i], 1'b1);
        check_frame("sync_in_payload", 8'h0B, 1);
    endtask

    task automatic test_reset_mid();
        assert_reset();
        release_reset();
        send_sync(0);
        for (int i = 0; i < 4; i++) step(1'($urandom), 1'b1);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: got %b required 1", bus.busy);
        end
        assert_reset();
        check_zero_outputs("mid_reset");
        release_reset();
        send_sync(0);
        send_word(8'hFF, 0);
        check_frame("after_mid", 8'hFF, 1);
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) send_sync(0);
            step(1'($urandom), ($urandom_range(0, 3) != 0));
        end
        while (m_cap) step(1'($urandom), 1'b1);
        checks++;
        if (cyc_bad !== 0 || dbl !== 0) begin
            failures++;
            $display("FAIL random_cycle: %0d cycles differed, %0d double pulses, required 0/0", cyc_bad, dbl);
        end
        checks++;
        if (bus.frame_count !== m_count || obs_pulses % 256 !== int'(m_count)) begin
            failures++;
            $display("FAIL random_count: got %0d (pulses %0d) required %0d", bus.frame_count, obs_pulses, m_count);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] w;
        assert_reset();
        release_reset();
        w = '0;
        for (int f = 0; f < 256; f++) begin
            w = WIDTH'($urandom);
            send_sync(0);
            send_word(w, ($urandom_range(0, 7) == 0));
        end
        check_frame("wrap", w, 256);
        checks++;
        if (bus.frame_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_zero: got %0d required 0", bus.frame_count);
        end
    endtask

    initial begin
        sync_pat   = 4'b1011;
        rst_n      = 1'b0;
        bus.bit_in = 1'b0;
        bus.bit_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_init");
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_junk();
        test_sync_in_payload();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
